triangle_fifo_reader: RTL and testbench

- Read-side controller for the on-chip triangle FIFO RAM: owns the read pointer, drives the RAM read port, absorbs the RAM's 1-cycle registered read latency, and presents one unpacked triangle at a time to the rasterizer over a valid/ready handshake.
- Sits between the triangle FIFO RAM (read port) and the rasterizer front end.
- The write-side controller owns the write pointer.

---
 rtl/triangle_fifo_reader.sv | 161 ++++++++++++++++
 tb/tb_triangle_fifo_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_fifo_reader.sv
// triangle_fifo_reader
// Read side of the triangle FIFO RAM. Owns the read pointer, issues RAM reads,
// absorbs the one-cycle registered read latency with a two-entry skid buffer,
// and hands one unpacked triangle at a time to the rasterizer (valid/ready).
module triangle_fifo_reader #(
  parameter int DEPTH   = 100,
  parameter int ADDR_W  = 7,
  parameter int COORD_W = 10
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [ADDR_W:0]        i_wr_ptr,
  input  logic                   i_flush,
  input  logic [6*COORD_W-1:0]   i_ram_data,
  output logic                   o_r_en,
  output logic [ADDR_W-1:0]      o_r_addr,
  output logic [ADDR_W:0]        o_rd_ptr,
  output logic                   o_is_empty,
  output logic                   o_tri_valid,
  input  logic                   i_tri_ready,
  output logic [COORD_W-1:0]     o_v0x,
  output logic [COORD_W-1:0]     o_v0y,
  output logic [COORD_W-1:0]     o_v1x,
  output logic [COORD_W-1:0]     o_v1y,
  output logic [COORD_W-1:0]     o_v2x,
  output logic [COORD_W-1:0]     o_v2y,
  output logic [15:0]            o_tri_count
);

  localparam int WORD_W = 6 * COORD_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  // Read pointer: [ADDR_W-1:0] index, [ADDR_W] lap bit.
  logic [ADDR_W:0]   r_rd_ptr;
  // Skid buffer: entry 0 is the head and drives the vertex outputs.
  logic [WORD_W-1:0] r_buf_head;
  logic [WORD_W-1:0] r_buf_tail;
  logic [1:0]        r_occ;
  // Set while a RAM read is outstanding; its data arrives next cycle.
  logic              r_inflight;
  logic [15:0]       r_tri_count;

  logic              w_is_empty;
  logic              w_pop;
  logic              w_capture;
  logic              w_issue;
  logic [1:0]        w_occ_after_pop;
  logic [2:0]        w_pending;
  logic [1:0]        w_occ_next;
  logic [ADDR_W:0]   w_rd_ptr_inc;
  logic [WORD_W-1:0] w_buf_head_next;
  logic [WORD_W-1:0] w_buf_tail_next;
  logic [5:0][COORD_W-1:0] w_vtx;

  assign w_is_empty = (r_rd_ptr == i_wr_ptr);

  // Handshake, issue decision and occupancy bookkeeping.
  always_comb begin
    w_pop           = 1'b0;
    w_capture       = 1'b0;
    w_occ_after_pop = r_occ;
    w_pending       = 3'd0;
    w_issue         = 1'b0;
    w_occ_next      = r_occ;

    w_pop           = (r_occ != 2'd0) && i_tri_ready;
    w_capture       = r_inflight;
    w_occ_after_pop = r_occ - {1'b0, w_pop};
    // A read already in flight reserves a buffer slot just like a stored entry,
    // so the buffer can never be overrun regardless of backpressure.
    w_pending       = {1'b0, w_occ_after_pop} + {2'b00, r_inflight};
    w_issue         = !w_is_empty && !i_flush && (w_pending < 3'd2);
    w_occ_next      = w_occ_after_pop + {1'b0, w_capture};
  end

  // Next read pointer: wrap the index at DEPTH-1 and flip the lap bit.
  always_comb begin
    w_rd_ptr_inc = r_rd_ptr;
    if (r_rd_ptr[ADDR_W-1:0] == LAST_IDX) begin
      w_rd_ptr_inc = {~r_rd_ptr[ADDR_W], {ADDR_W{1'b0}}};
    end else begin
      w_rd_ptr_inc = r_rd_ptr + (ADDR_W+1)'(1);
    end
  end

  // Buffer data movement: pop shifts tail to head, capture fills the first free slot.
  always_comb begin
    w_buf_head_next = r_buf_head;
    w_buf_tail_next = r_buf_tail;
    if (w_pop) begin
      w_buf_head_next = r_buf_tail;
    end
    // Capture never finds both slots occupied after the pop: the issue rule
    // reserved a slot for this word when the read was launched.
    if (w_capture) begin
      if (w_occ_after_pop == 2'd0) begin
        w_buf_head_next = i_ram_data;
      end else begin
        w_buf_tail_next = i_ram_data;
      end
    end
  end

  // Pointer, occupancy, in-flight flag and delivered-triangle counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr    <= '0;
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_tri_count <= 16'd0;
    end else if (i_flush) begin
      // Jump to the writer's pointer; whatever was stored or in flight is dropped.
      r_rd_ptr    <= i_wr_ptr;
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_tri_count <= 16'd0;
    end else begin
      if (w_issue) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_inflight <= w_issue;
      r_occ      <= w_occ_next;
      if (w_pop) begin
        r_tri_count <= r_tri_count + 16'd1;
      end
    end
  end

  // Buffer storage; contents are left alone on flush since occupancy gates validity.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf_head <= '0;
      r_buf_tail <= '0;
    end else if (!i_flush) begin
      r_buf_head <= w_buf_head_next;
      r_buf_tail <= w_buf_tail_next;
    end
  end

  // Unpack the head word: v0x in the top COORD_W bits down to v2y at the bottom.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_unpack
      assign w_vtx[5-gi] = r_buf_head[WORD_W-1-gi*COORD_W -: COORD_W];
    end
  endgenerate

  assign o_v0x       = w_vtx[5];
  assign o_v0y       = w_vtx[4];
  assign o_v1x       = w_vtx[3];
  assign o_v1y       = w_vtx[2];
  assign o_v2x       = w_vtx[1];
  assign o_v2y       = w_vtx[0];

  assign o_r_en      = w_issue;
  assign o_r_addr    = r_rd_ptr[ADDR_W-1:0];
  assign o_rd_ptr    = r_rd_ptr;
  assign o_is_empty  = w_is_empty;
  assign o_tri_valid = (r_occ != 2'd0);
  assign o_tri_count = r_tri_count;

endmodule

// File: tb/tb_triangle_fifo_reader.sv
// tb_triangle_fifo_reader
// Drives a registered-read RAM model and a writer pointer, and scores every
// delivered triangle against a queue of written triangles in write order.
module tb_triangle_fifo_reader;

  localparam int DEPTH   = 100;
  localparam int ADDR_W  = 7;
  localparam int COORD_W = 10;
  localparam int WORD_W  = 6 * COORD_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush = 1'b0;
  logic                 ready = 1'b0;
  logic [ADDR_W:0]      wr_ptr = '0;
  logic [WORD_W-1:0]    ram_data = '0;
  logic                 r_en;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W:0]      rd_ptr;
  logic                 is_empty;
  logic                 tri_valid;
  logic [COORD_W-1:0]   v0x, v0y, v1x, v1y, v2x, v2y;
  logic [15:0]          tri_count;

  logic [WORD_W-1:0]    mem [0:DEPTH-1];

  triangle_fifo_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .COORD_W(COORD_W)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr_ptr(wr_ptr), .i_flush(flush),
    .i_ram_data(ram_data), .o_r_en(r_en), .o_r_addr(r_addr), .o_rd_ptr(rd_ptr),
    .o_is_empty(is_empty), .o_tri_valid(tri_valid), .i_tri_ready(ready),
    .o_v0x(v0x), .o_v0y(v0y), .o_v1x(v1x), .o_v1y(v1y), .o_v2x(v2x), .o_v2y(v2y),
    .o_tri_count(tri_count)
  );

  always #5 clk = ~clk;

  // RAM read port with one cycle of registered latency.
  always @(posedge clk) begin
    if (r_en) ram_data <= mem[r_addr];
  end

  wire [WORD_W-1:0] out_word = {v0x, v0y, v1x, v1y, v2x, v2y};

  int checks = 0;
  int failures = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state.
  logic [WORD_W-1:0] exp_q[$];
  logic [15:0]       model_count = 16'd0;
  int                run_cur = 0;
  int                run_max = 0;
  int                ren_count = 0;
  logic [ADDR_W-1:0] addr_q[$];
  logic              hold_prev = 1'b0;
  logic [WORD_W-1:0] hold_word = '0;

  function automatic logic [ADDR_W:0] ptr_next(input logic [ADDR_W:0] p);
    int idx;
    idx = int'(p[ADDR_W-1:0]);
    if (idx == DEPTH - 1) return {~p[ADDR_W], {ADDR_W{1'b0}}};
    return {p[ADDR_W], ADDR_W'(idx + 1)};
  endfunction

  // Monitor: scoreboard every handshake, track counts, check backpressure stability.
  always @(negedge clk) begin
    logic [WORD_W-1:0] exp_w;
    if (hold_prev) begin
      check_value("hold_valid", 64'(tri_valid), 64'd1);
      check_value("hold_data", 64'(out_word), 64'(hold_word));
    end
    check_value("tri_count", 64'(tri_count), 64'(model_count));
    hold_prev = 1'b0;
    if (rst || flush) begin
      exp_q.delete();
      model_count = 16'd0;
      run_cur = 0;
    end else begin
      if (tri_valid) begin
        run_cur++;
        if (run_cur > run_max) run_max = run_cur;
      end else begin
        run_cur = 0;
      end
      if (r_en) begin
        ren_count++;
        addr_q.push_back(r_addr);
      end
      if (tri_valid && ready) begin
        check_value("pop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check_value("pop_data", 64'(out_word), 64'(exp_w));
          model_count = model_count + 16'd1;
        end
      end else if (tri_valid) begin
        hold_prev = 1'b1;
        hold_word = out_word;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [WORD_W-1:0] w);
    mem[wr_ptr[ADDR_W-1:0]] = w;
    wr_ptr = ptr_next(wr_ptr);
    exp_q.push_back(w);
  endtask

  function automatic logic [WORD_W-1:0] rand_word();
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    return r64[WORD_W-1:0];
  endfunction

  task automatic write_tri(input logic [WORD_W-1:0] w);
    tick();
    put_word(w);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    check_value("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WORD_W-1:0] first_w;
    logic [WORD_W-1:0] w1;
    logic [ADDR_W-1:0] wrap_addr [0:3];

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_value("rst_valid", 64'(tri_valid), 64'd0);
    check_value("rst_rd_ptr", 64'(rd_ptr), 64'd0);
    check_value("rst_count", 64'(tri_count), 64'd0);
    check_value("rst_empty", 64'(is_empty), 64'd1);
    check_value("rst_ren", 64'(r_en), 64'd0);
    check_value("rst_vtx", 64'(out_word), 64'd0);

    // Single triangle latency and unpacking.
    w1 = {10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6};
    tick();
    ready = 1'b1;
    write_tri(w1);
    @(negedge clk);
    check_value("lat_ren", 64'(r_en), 64'd1);
    check_value("lat_addr", 64'(r_addr), 64'd0);
    @(negedge clk);
    check_value("lat_valid_early", 64'(tri_valid), 64'd0);
    @(negedge clk);
    check_value("lat_valid", 64'(tri_valid), 64'd1);
    check_value("v0x", 64'(v0x), 64'd1);
    check_value("v0y", 64'(v0y), 64'd2);
    check_value("v1x", 64'(v1x), 64'd3);
    check_value("v1y", 64'(v1y), 64'd4);
    check_value("v2x", 64'(v2x), 64'd5);
    check_value("v2y", 64'(v2y), 64'd6);
    @(negedge clk);
    check_value("lat_count", 64'(tri_count), 64'd1);
    check_value("lat_valid_drop", 64'(tri_valid), 64'd0);
    $display("txn single: count=%0d", tri_count);

    // Wrap: park both pointers at index 98 via flush, then write four.
    tick();
    flush = 1'b1;
    wr_ptr = {1'b0, 7'd98};
    tick();
    flush = 1'b0;
    @(negedge clk);
    check_value("wrap_start_ptr", 64'(rd_ptr), 64'd98);
    check_value("wrap_start_empty", 64'(is_empty), 64'd1);
    addr_q.delete();
    for (int i = 0; i < 4; i++) write_tri(rand_word());
    drain(50);
    repeat (2) @(negedge clk);
    wrap_addr[0] = 7'd98; wrap_addr[1] = 7'd99; wrap_addr[2] = 7'd0; wrap_addr[3] = 7'd1;
    check_value("wrap_nreads", 64'(addr_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) check_value("wrap_addr", 64'(addr_q[i]), 64'(wrap_addr[i]));
    check_value("wrap_rd_ptr", 64'(rd_ptr), 64'({1'b1, 7'd2}));
    check_value("wrap_empty", 64'(is_empty), 64'd1);
    $display("txn wrap: rd_ptr=%0h", rd_ptr);

    // Backpressure: five stored, ready low for ten cycles.
    tick();
    ready = 1'b0;
    ren_count = 0;
    first_w = rand_word();
    write_tri(first_w);
    for (int i = 0; i < 4; i++) write_tri(rand_word());
    repeat (10) @(negedge clk);
    check_value("bp_reads", 64'(ren_count), 64'd2);
    check_value("bp_valid", 64'(tri_valid), 64'd1);
    check_value("bp_head", 64'(out_word), 64'(first_w));
    tick();
    ready = 1'b1;
    run_cur = 0;
    run_max = 0;
    drain(40);
    repeat (3) @(negedge clk);
    check_value("bp_run", 64'(run_max), 64'd5);
    $display("txn backpressure: reads=%0d run=%0d", ren_count, run_max);

    // Streaming 50 triangles from a cleared count.
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_cur = 0;
    run_max = 0;
    for (int i = 0; i < 50; i++) write_tri(rand_word());
    drain(100);
    repeat (3) @(negedge clk);
    check_value("stream_run", 64'(run_max), 64'd50);
    check_value("stream_count", 64'(tri_count), 64'd50);
    $display("txn stream: run=%0d count=%0d", run_max, tri_count);

    // Flush with triangles buffered, in flight and stored.
    tick();
    ready = 1'b0;
    for (int i = 0; i < 7; i++) write_tri(rand_word());
    repeat (4) @(negedge clk);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check_value("flush_ren", 64'(r_en), 64'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check_value("flush_valid", 64'(tri_valid), 64'd0);
    check_value("flush_rd_ptr", 64'(rd_ptr), 64'(wr_ptr));
    check_value("flush_empty", 64'(is_empty), 64'd1);
    check_value("flush_count", 64'(tri_count), 64'd0);
    tick();
    ready = 1'b1;
    write_tri(rand_word());
    drain(20);
    repeat (5) @(negedge clk);
    check_value("flush_after_count", 64'(tri_count), 64'd1);
    $display("txn flush: count=%0d", tri_count);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      tick();
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && exp_q.size() < 90) put_word(rand_word());
    end
    tick();
    ready = 1'b1;
    drain(300);
    repeat (3) @(negedge clk);
    check_value("rand_empty", 64'(is_empty), 64'd1);
    $display("txn random: count=%0d", tri_count);

    // Reset mid-stream.
    for (int i = 0; i < 10; i++) write_tri(rand_word());
    @(negedge clk);
    check_value("mid_valid", 64'(tri_valid), 64'd1);
    tick();
    rst = 1'b1;
    wr_ptr = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_value("mrst_valid", 64'(tri_valid), 64'd0);
    check_value("mrst_rd_ptr", 64'(rd_ptr), 64'd0);
    check_value("mrst_ren", 64'(r_en), 64'd0);
    repeat (5) @(negedge clk);
    check_value("mrst_stale", 64'(tri_valid), 64'd0);
    write_tri(rand_word());
    drain(20);
    repeat (3) @(negedge clk);
    check_value("mrst_count", 64'(tri_count), 64'd1);
    $display("txn reset: count=%0d", tri_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
